// File: rtl/dmem_preload_writer.sv
// dmem_preload_writer
//   Streams a length-prefixed word image (header N, then N payload words) from a
//   valid/ready source into the data-memory write port, holding the CPU in reset
//   until the image has been loaded cleanly.
//   Optional feature macro: DMEM_PRELOAD_CHECKSUM_EN adds a trailing checksum
//   word (DATA_W-bit modulo sum of the payload) that must match before release.
module dmem_preload_writer #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_BF_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal length: the image must fit between BASE_ADDR and the top.
    localparam int              MAX_N_I = (1 << ADDR_W) - BASE_ADDR;
    localparam logic [ADDR_W:0] MAX_N   = MAX_N_I[ADDR_W:0];
    localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];

`ifdef DMEM_PRELOAD_CHECKSUM_EN
    localparam state_t S_POST = S_CHK;
`else
    localparam state_t S_POST = S_DONE;
`endif

    state_t            state_q, state_d;
    logic              armed_q;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
`ifdef DMEM_PRELOAD_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    logic            hs;
    logic [ADDR_W:0] hdr_n;

    assign hs    = in_valid & in_ready;
    assign hdr_n = in_data[ADDR_W:0];

    // Status outputs decode directly from the state register.
    assign busy          = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
    assign in_ready      = busy;
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERR);
    assign cpu_rst       = (state_q != S_DONE);
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign words_written = cnt_q;

    // Next-state and write-port logic; a write is issued the cycle after each payload handshake.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        wr_addr_d   = wr_addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef DMEM_PRELOAD_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // armed_q masks a start that arrives on the first edge after reset release
                if (start && armed_q) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
`ifdef DMEM_PRELOAD_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_HDR: begin
                if (hs) begin
                    if (hdr_n > MAX_N) begin
                        state_d = S_ERR;
                    end else if (hdr_n == '0) begin
                        state_d = S_POST;
                    end else begin
                        state_d    = S_LOAD;
                        n_d        = hdr_n;
                        wr_addr_d  = BASE;
                        mem_addr_d = BASE;
                    end
                end
            end
            S_LOAD: begin
                if (hs) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_addr_q;
                    mem_wdata_d = in_data;
                    wr_addr_d   = wr_addr_q + 1'b1;
                    cnt_d       = cnt_q + 1'b1;
`ifdef DMEM_PRELOAD_CHECKSUM_EN
                    sum_d       = sum_q + in_data;
`endif
                    if ((cnt_q + 1'b1) == n_q) begin
                        state_d = S_POST;
                    end
                end
            end
`ifdef DMEM_PRELOAD_CHECKSUM_EN
            S_CHK: begin
                if (hs) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered write-port update; reset kills any pending write immediately.
    always_ff @(posedge clk or negedge rst_BF_n) begin
        if (!rst_BF_n) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            n_q         <= '0;
            cnt_q       <= '0;
            wr_addr_q   <= BASE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE;
            mem_wdata_q <= '0;
`ifdef DMEM_PRELOAD_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            armed_q     <= 1'b1;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            wr_addr_q   <= wr_addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef DMEM_PRELOAD_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_preload_writer.sv
// Directed testbench for dmem_preload_writer (ADDR_W=10, DATA_W=32, BASE_ADDR=0).
module tb_dmem_preload_writer;

    logic        clk = 1'b0;
    logic        rst_BF_n;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_written;

    int tests_run    = 0;
    int tests_failed = 0;

    // write log captured on the falling edge
    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          cyc = 0;

    dmem_preload_writer #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_BF_n(rst_BF_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
        .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_chk(input logic [31:0] s);
`ifdef DMEM_PRELOAD_CHECKSUM_EN
        in_valid = 1'b1;
        in_data  = s;
        step();
        in_valid = 1'b0;
`else
        in_data = s;
`endif
    endtask

    task automatic test_reset();
        rst_BF_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        step(); step();
        tests_run++;
        if ({busy, done, error, cpu_rst, in_ready} !== 5'b00010) begin
            tests_failed++;
            $display("FAIL reset_status: got %b want 00010", {busy, done, error, cpu_rst, in_ready});
        end
        tests_run++;
        if ({mem_we, mem_addr, mem_wdata, words_written} !== {1'b0, 10'd0, 32'd0, 11'd0}) begin
            tests_failed++;
            $display("FAIL reset_regs: we=%b addr=%0d data=%h ww=%0d want 0/0/0/0", mem_we, mem_addr, mem_wdata, words_written);
        end
        // start held across the first edge after release must be ignored
        rst_BF_n = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_start: busy=%b want 0", busy);
        end
        step();
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        clear_log();
        pulse_start();
        tests_run++;
        if ({busy, done, error, cpu_rst, in_ready} !== 5'b10011) begin
            tests_failed++;
            $display("FAIL basic_hdr_status: got %b want 10011", {busy, done, error, cpu_rst, in_ready});
        end
        in_valid = 1'b1;
        in_data = 32'd3;   step();
        in_data = 32'hA;   step();
        in_data = 32'hB;   step();
        in_data = 32'hC;   step();
        in_valid = 1'b0;
        tests_run++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd2, 32'hC}) begin
            tests_failed++;
            $display("FAIL basic_last_write: we=%b addr=%0d data=%h want 1/2/c", mem_we, mem_addr, mem_wdata);
        end
        send_chk(32'h21);
        tests_run++;
        if ({busy, done, error, cpu_rst, in_ready, words_written} !== {5'b01000, 11'd3}) begin
            tests_failed++;
            $display("FAIL basic_done: status=%b ww=%0d want 01000/3", {busy, done, error, cpu_rst, in_ready}, words_written);
        end
        step(); step();
        tests_run++;
        if (wa_q.size() != 3 || wa_q[0] !== 10'd0 || wa_q[1] !== 10'd1 || wa_q[2] !== 10'd2 ||
            wd_q[0] !== 32'hA || wd_q[1] !== 32'hB || wd_q[2] !== 32'hC ||
            wc_q[1] != wc_q[0] + 1 || wc_q[2] != wc_q[1] + 1) begin
            tests_failed++;
            $display("FAIL basic_writes: count=%0d want 3 at addr 0,1,2 data a,b,c on consecutive cycles", wa_q.size());
        end
        $display("[TB] basic load: %0d writes", wa_q.size());
    endtask

    task automatic test_gaps();
        clear_log();
        pulse_start();
        in_valid = 1'b1;
        in_data = 32'd2;    step();
        in_data = 32'h11;   step();
        in_valid = 1'b0;
        start = 1'b1;       step();
        start = 1'b0;
        tests_run++;
        if ({busy, done, words_written} !== {1'b1, 1'b0, 11'd1}) begin
            tests_failed++;
            $display("FAIL gaps_start_ignored: busy=%b done=%b ww=%0d want 1/0/1", busy, done, words_written);
        end
        step();
        in_valid = 1'b1;
        in_data = 32'h22;   step();
        in_valid = 1'b0;
        send_chk(32'h33);
        tests_run++;
        if ({busy, done, error, cpu_rst, words_written} !== {4'b0100, 11'd2}) begin
            tests_failed++;
            $display("FAIL gaps_done: status=%b ww=%0d want 0100/2", {busy, done, error, cpu_rst}, words_written);
        end
        step(); step();
        tests_run++;
        if (wa_q.size() != 2 || wa_q[0] !== 10'd0 || wa_q[1] !== 10'd1 ||
            wd_q[0] !== 32'h11 || wd_q[1] !== 32'h22) begin
            tests_failed++;
            $display("FAIL gaps_writes: count=%0d want 2 at addr 0,1 data 11,22", wa_q.size());
        end
        $display("[TB] gapped load: %0d writes", wa_q.size());
    endtask

    task automatic test_zero_len();
        clear_log();
        pulse_start();
        in_valid = 1'b1;
        in_data  = 32'd0;
        step();
        in_valid = 1'b0;
        send_chk(32'd0);
        tests_run++;
        if ({busy, done, error, cpu_rst, in_ready} !== 5'b01000) begin
            tests_failed++;
            $display("FAIL zero_done: got %b want 01000", {busy, done, error, cpu_rst, in_ready});
        end
        step(); step();
        tests_run++;
        if (wa_q.size() != 0 || words_written !== 11'd0) begin
            tests_failed++;
            $display("FAIL zero_writes: count=%0d ww=%0d want 0/0", wa_q.size(), words_written);
        end
        $display("[TB] zero-length load");
    endtask

    task automatic test_err_recover();
        clear_log();
        pulse_start();
        in_valid = 1'b1;
        in_data  = 32'd1025;
        step();
        in_valid = 1'b0;
        tests_run++;
        if ({busy, done, error, cpu_rst, in_ready} !== 5'b00110) begin
            tests_failed++;
            $display("FAIL err_status: got %b want 00110", {busy, done, error, cpu_rst, in_ready});
        end
        step(); step();
        tests_run++;
        if (wa_q.size() != 0) begin
            tests_failed++;
            $display("FAIL err_writes: count=%0d want 0", wa_q.size());
        end
        pulse_start();
        tests_run++;
        if ({busy, done, error, cpu_rst, in_ready} !== 5'b10011) begin
            tests_failed++;
            $display("FAIL err_restart: got %b want 10011", {busy, done, error, cpu_rst, in_ready});
        end
        // upper header bits beyond [10:0] are ignored: N = 1
        in_valid = 1'b1;
        in_data = 32'hFFFF_F801; step();
        in_data = 32'd5;         step();
        in_valid = 1'b0;
        send_chk(32'd5);
        tests_run++;
        if ({busy, done, error, cpu_rst, words_written} !== {4'b0100, 11'd1}) begin
            tests_failed++;
            $display("FAIL err_recover_done: status=%b ww=%0d want 0100/1", {busy, done, error, cpu_rst}, words_written);
        end
        step(); step();
        tests_run++;
        if (wa_q.size() != 1 || wa_q[0] !== 10'd0 || wd_q[0] !== 32'd5) begin
            tests_failed++;
            $display("FAIL err_recover_writes: count=%0d want 1 write addr 0 data 5", wa_q.size());
        end
        $display("[TB] error then recovery");
    endtask

    task automatic test_reset_midload();
        clear_log();
        pulse_start();
        tests_run++;
        if ({busy, done, cpu_rst} !== 3'b101) begin
            tests_failed++;
            $display("FAIL midrst_restart_from_done: got %b want 101", {busy, done, cpu_rst});
        end
        in_valid = 1'b1;
        in_data = 32'd4;    step();
        in_data = 32'h31;   step();
        in_data = 32'h32;   step();
        in_valid = 1'b0;
        rst_BF_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_we, busy, done, error, cpu_rst, words_written} !== {5'b00001, 11'd0}) begin
            tests_failed++;
            $display("FAIL midrst_async: we=%b status=%b ww=%0d want 0/0001/0", mem_we, {busy, done, error, cpu_rst}, words_written);
        end
        step(); step();
        tests_run++;
        if (wa_q.size() < 1 || wa_q.size() > 2 || wa_q[0] !== 10'd0 || wd_q[0] !== 32'h31 ||
            (wa_q.size() == 2 && (wa_q[1] !== 10'd1 || wd_q[1] !== 32'h32))) begin
            tests_failed++;
            $display("FAIL midrst_writes: count=%0d want addr 0 (and optionally 1) only", wa_q.size());
        end
        rst_BF_n = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if ({busy, cpu_rst} !== 2'b01) begin
            tests_failed++;
            $display("FAIL midrst_release: busy=%b cpu_rst=%b want 0/1", busy, cpu_rst);
        end
        step();
        $display("[TB] reset mid-load: %0d writes", wa_q.size());
    endtask

    task automatic test_max_len();
        int bad;
        clear_log();
        pulse_start();
        in_valid = 1'b1;
        in_data  = 32'd1024;
        step();
        for (int i = 0; i < 1024; i++) begin
            in_data = i * 3;
            step();
        end
        in_valid = 1'b0;
        send_chk(32'd1571328);
        tests_run++;
        if ({busy, done, error, cpu_rst, words_written} !== {4'b0100, 11'd1024}) begin
            tests_failed++;
            $display("FAIL max_done: status=%b ww=%0d want 0100/1024", {busy, done, error, cpu_rst}, words_written);
        end
        step(); step();
        bad = 0;
        if (wa_q.size() != 1024) bad++;
        else begin
            for (int i = 0; i < 1024; i++) begin
                if (wa_q[i] !== 10'(i) || wd_q[i] !== 32'(i * 3)) bad++;
            end
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL max_writes: count=%0d bad=%0d want 1024 writes addr i data 3*i", wa_q.size(), bad);
        end
        $display("[TB] max-length load: %0d writes", wa_q.size());
    endtask

`ifdef DMEM_PRELOAD_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        in_valid = 1'b1;
        in_data = 32'd3; step();
        in_data = 32'd1; step();
        in_data = 32'd2; step();
        in_data = 32'd3; step();
        in_valid = 1'b0;
        tests_run++;
        if ({busy, done, error, cpu_rst, in_ready} !== 5'b10011) begin
            tests_failed++;
            $display("FAIL chk_wait: got %b want 10011", {busy, done, error, cpu_rst, in_ready});
        end
        send_chk(32'd6);
        tests_run++;
        if ({busy, done, error, cpu_rst} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL chk_good: got %b want 0100", {busy, done, error, cpu_rst});
        end
        pulse_start();
        in_valid = 1'b1;
        in_data = 32'd3; step();
        in_data = 32'd1; step();
        in_data = 32'd2; step();
        in_data = 32'd3; step();
        in_valid = 1'b0;
        send_chk(32'd7);
        tests_run++;
        if ({busy, done, error, cpu_rst} !== 4'b0011) begin
            tests_failed++;
            $display("FAIL chk_bad: got %b want 0011", {busy, done, error, cpu_rst});
        end
        step();
        $display("[TB] checksum good/bad");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_zero_len();
        test_err_recover();
        test_reset_midload();
        test_max_len();
`ifdef DMEM_PRELOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
